rv_decode_stage: RTL and testbench
==================================

# rv_decode_stage

Registered RV32I(+timer) instruction decode stage between fetch and execute. It replaces the purely combinational control unit with a valid/ready pipelined stage holding a 2-entry skid buffer. It also adds per-channel timer-enable state for a parametrised number of timers and strict illegal-instruction detection with a saturating error counter. Output control bundle feeds the ALU, branch unit, LSU and timer block.

## Interface

Parameters:
- ALU_W, 6, width of ALU control code (≥6)
- TIMER_CH, 4, number of timer channels (1–8)
- ERR_CNT_W, 8, width of illegal-instruction counter

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  fetch presents instruction
- in_ready  out  1  stage can accept; = !skid_valid
- in_instr  in  32  raw instruction
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts bundle
- out_alu_cntrl  out  ALU_W  ALU operation code
- out_mem_to_reg, out_load, out_store, out_jump, out_lui  out  1 each  class strobes
- out_branch  out  6  one-hot {bgeu,bltu,bge,blt,bne,beq}
- out_illegal  out  1  bundle is an illegal instruction
- out_funct3  out  3  passed through for LSU width select
- timer_en  out  TIMER_CH  per-channel enable state
- illegal_cnt  out  ERR_CNT_W  saturating count of accepted illegal instructions

## Operation

- Decode is combinational on in_instr; result is registered into output register or skid register. Opcode = [6:0], funct3 = [14:12], funct7 = [31:25].
- ALU codes (decimal): R-type ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9; I-type ADDI10 SLLI11 SLTI12 SLTIU13 XORI14 SRLI15 ORI16 ANDI17 (SRAI also 15, funct7 0100000 → code 7); loads LB18 LH19 LW20 LBU21 LHU22; stores SB23 SH24 SW25; BEQ26 BNE27 BLT28 BGE29 BLTU30 BGEU31; JAL32 TIM_PSC_I33 TIM_ARR_I34 TIM_PSC_REG35 TIM_ARR_REG36 LUI37 JALR38; illegal/none = all ones.
- Loads (0000011): out_load=out_mem_to_reg=1. Stores (0100011): out_store=1. Branches (1100011): funct3 000/001/100/101/110/111 → beq/bne/blt/bge/bltu/bgeu bit. JAL (1101111)/JALR (1100111, funct3 000): out_jump=1. LUI (0110111): out_lui=1.
- Illegal: unknown opcode; R-type funct7 ∉ {0000000, 0100000}, or 0100000 with funct3 ∉ {000,101}; SLLI funct7≠0; SRLI/SRAI funct7 ∉ {0000000,0100000}; load funct3 ∈ {011,110,111}; store funct3 ≥ 011; branch funct3 ∈ {010,011}; JALR funct3≠0; timer funct3 ∈ {011,110}; timer enable/disable with channel funct7 ≥ TIMER_CH. Illegal → all strobes 0, alu all ones, out_illegal=1.
- Timer opcode 0100101: funct3 000 sets timer_en[funct7], 111 clears it (alu all ones, no strobes); 001/010/100/101 → codes 33/34/35/36.
- Side effects (timer_en, illegal_cnt) occur on input acceptance (in_valid && in_ready), visible next cycle, independent of downstream stall. illegal_cnt saturates at all ones.

## Timing

- Reset: out_valid=0, skid empty (in_ready=1 next cycle), out_alu_cntrl=all ones, all strobes/out_branch/out_illegal/out_funct3=0, timer_en=0, illegal_cnt=0. Reset mid-transfer discards both held entries.
- Latency 1 cycle: instruction accepted at edge N is on outputs after edge N (out_valid=1) if output register free or draining.
- Output register loads when !out_valid || out_ready: from skid if skid_valid, else from input. Input goes to skid when out_valid && !out_ready and skid empty.
- Throughput 1/cycle with out_ready held high; in_ready depends only on registers (no combinational in→out path).
- Output bundle stable while out_valid && !out_ready. Order strictly preserved.
- Simultaneous timer set and clear impossible (one instruction/cycle); enable of already-enabled channel is no-op.

## Test plan

- Reset, then ADD (0x002081B3) with out_ready=1 → next cycle out_valid=1, alu=0, strobes 0; SUB 0x402081B3 → alu=1.
- Backpressure: out_ready=0, stream LW, SW, BEQ → first in output, second in skid, in_ready=0; release → LW/SW/BEQ emerge in order, alu 20/25/26, beq bit set on third.
- Timer: opcode 0100101 funct3 000 funct7=2 → timer_en=0b0100 one cycle after accept; funct3 111 funct7=2 → 0b0000; funct7=5 with TIMER_CH=4 → out_illegal=1, timer_en unchanged.
- Illegal: 0xFFFFFFFF, load funct3 111, SLLI funct7=0100000 → out_illegal=1, alu=63, illegal_cnt counts 3; with ERR_CNT_W=2 after 5 illegals count stays 3.
- Reset asserted with both entries full → next cycle out_valid=0, in_ready=1, timer_en=0.
- Back-to-back BLTU, BGEU, JALR, LUI at full rate → one output per cycle, codes 30/31/38/37, correct one-hot branch bits.

Source files
------------

// File: rtl/rv_decode_stage.sv
// rtl/rv_decode_stage.sv - registered RV32I(+timer) decode stage with 2-entry skid buffer
//
// Decodes a raw instruction into the control bundle consumed by the ALU,
// branch unit, LSU and timer block. The bundle is registered behind a
// valid/ready handshake. A skid register makes in_ready depend only on state.
//
// Ports:
//   clk, reset              clock (rising edge), synchronous active-high reset
//   in_valid, in_ready      fetch-side handshake (in_ready = !skid_valid)
//   in_instr[31:0]          raw instruction
//   out_valid, out_ready    execute-side handshake
//   out_alu_cntrl[ALU_W]    ALU operation code (all ones = none/illegal)
//   out_mem_to_reg, out_load, out_store, out_jump, out_lui   class strobes
//   out_branch[5:0]         one-hot {bgeu,bltu,bge,blt,bne,beq}
//   out_illegal             bundle is an illegal instruction
//   out_funct3[2:0]         funct3 pass-through for LSU width select
//   timer_en[TIMER_CH]      per-channel timer enable state
//   illegal_cnt[ERR_CNT_W]  saturating count of accepted illegal instructions
module rv_decode_stage #(
  parameter int ALU_W     = 6,
  parameter int TIMER_CH  = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ALU_W-1:0]     out_alu_cntrl,
  output logic                 out_mem_to_reg,
  output logic                 out_load,
  output logic                 out_store,
  output logic                 out_jump,
  output logic                 out_lui,
  output logic [5:0]           out_branch,
  output logic                 out_illegal,
  output logic [2:0]           out_funct3,
  output logic [TIMER_CH-1:0]  timer_en,
  output logic [ERR_CNT_W-1:0] illegal_cnt
);

  // Bundle layout: {alu, mem_to_reg, load, store, jump, lui, branch[5:0], illegal, funct3[2:0]}
  localparam int BW = ALU_W + 15;
  localparam logic [BW-1:0] RST_BUNDLE = {{ALU_W{1'b1}}, 15'b0};
  localparam logic [6:0] TIMER_CH_7 = 7'(TIMER_CH);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  // Register and immediate fields are not needed for control decode.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{in_instr[24:15], in_instr[11:7]};

  logic [5:0] code;
  logic       ill, mtr, ld, st, jmp, lui, tset, tclr;
  logic [5:0] br;

  always_comb begin
    code = 6'h3F;
    ill  = 1'b0;
    mtr  = 1'b0;
    ld   = 1'b0;
    st   = 1'b0;
    jmp  = 1'b0;
    lui  = 1'b0;
    br   = 6'b0;
    tset = 1'b0;
    tclr = 1'b0;
    case (opcode)
      7'b0110011: begin
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  code = 6'd0;
            3'b001:  code = 6'd2;
            3'b010:  code = 6'd3;
            3'b011:  code = 6'd4;
            3'b100:  code = 6'd5;
            3'b101:  code = 6'd6;
            3'b110:  code = 6'd8;
            default: code = 6'd9;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          code = 6'd1;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
          code = 6'd7;
        end else begin
          ill = 1'b1;
        end
      end
      7'b0010011: begin
        case (funct3)
          3'b000: code = 6'd10;
          3'b001: if (funct7 == 7'b0000000) code = 6'd11; else ill = 1'b1;
          3'b010: code = 6'd12;
          3'b011: code = 6'd13;
          3'b100: code = 6'd14;
          3'b101: begin
            // SRAI shares the R-type SRA code
            if (funct7 == 7'b0000000)      code = 6'd15;
            else if (funct7 == 7'b0100000) code = 6'd7;
            else                           ill  = 1'b1;
          end
          3'b110:  code = 6'd16;
          default: code = 6'd17;
        endcase
      end
      7'b0000011: begin
        ld  = 1'b1;
        mtr = 1'b1;
        case (funct3)
          3'b000:  code = 6'd18;
          3'b001:  code = 6'd19;
          3'b010:  code = 6'd20;
          3'b100:  code = 6'd21;
          3'b101:  code = 6'd22;
          default: ill  = 1'b1;
        endcase
      end
      7'b0100011: begin
        st = 1'b1;
        case (funct3)
          3'b000:  code = 6'd23;
          3'b001:  code = 6'd24;
          3'b010:  code = 6'd25;
          default: ill  = 1'b1;
        endcase
      end
      7'b1100011: begin
        case (funct3)
          3'b000:  begin code = 6'd26; br = 6'b000001; end
          3'b001:  begin code = 6'd27; br = 6'b000010; end
          3'b100:  begin code = 6'd28; br = 6'b000100; end
          3'b101:  begin code = 6'd29; br = 6'b001000; end
          3'b110:  begin code = 6'd30; br = 6'b010000; end
          3'b111:  begin code = 6'd31; br = 6'b100000; end
          default: ill = 1'b1;
        endcase
      end
      7'b1101111: begin
        code = 6'd32;
        jmp  = 1'b1;
      end
      7'b1100111: begin
        if (funct3 == 3'b000) begin
          code = 6'd38;
          jmp  = 1'b1;
        end else begin
          ill = 1'b1;
        end
      end
      7'b0110111: begin
        code = 6'd37;
        lui  = 1'b1;
      end
      7'b0100101: begin
        // funct7 carries the channel index for enable/disable
        case (funct3)
          3'b000:  if (funct7 < TIMER_CH_7) tset = 1'b1; else ill = 1'b1;
          3'b111:  if (funct7 < TIMER_CH_7) tclr = 1'b1; else ill = 1'b1;
          3'b001:  code = 6'd33;
          3'b010:  code = 6'd34;
          3'b100:  code = 6'd35;
          3'b101:  code = 6'd36;
          default: ill  = 1'b1;
        endcase
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      code = 6'h3F;
      mtr  = 1'b0;
      ld   = 1'b0;
      st   = 1'b0;
      jmp  = 1'b0;
      lui  = 1'b0;
      br   = 6'b0;
    end
  end

  // Code 63 is the "none" marker and widens to all ones for any ALU_W.
  logic [ALU_W-1:0] dec_alu;
  assign dec_alu = (code == 6'h3F) ? {ALU_W{1'b1}} : ALU_W'(code);

  logic [BW-1:0] dec_bundle;
  assign dec_bundle = {dec_alu, mtr, ld, st, jmp, lui, br, ill, funct3};

  logic [BW-1:0] out_q, skid_q;
  logic          skid_valid;
  logic          accept, load_out;

  assign in_ready = !skid_valid;
  assign accept   = in_valid && in_ready;
  assign load_out = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_q      <= RST_BUNDLE;
      skid_valid <= 1'b0;
      skid_q     <= RST_BUNDLE;
    end else if (load_out) begin
      // in_ready is low while the skid is full, so accept cannot coincide with a skid drain
      if (skid_valid) begin
        out_q      <= skid_q;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_q     <= dec_bundle;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_q     <= dec_bundle;
      skid_valid <= 1'b1;
    end
  end

  assign {out_alu_cntrl, out_mem_to_reg, out_load, out_store, out_jump, out_lui,
          out_branch, out_illegal, out_funct3} = out_q;

  // Side effects take place at acceptance, regardless of downstream stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_en    <= '0;
      illegal_cnt <= '0;
    end else if (accept) begin
      for (int i = 0; i < TIMER_CH; i++) begin
        if (funct7 == 7'(i)) begin
          if (tset) timer_en[i] <= 1'b1;
          if (tclr) timer_en[i] <= 1'b0;
        end
      end
      if (ill && illegal_cnt != {ERR_CNT_W{1'b1}})
        illegal_cnt <= illegal_cnt + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rv_decode_stage.sv
// tb/tb_rv_decode_stage.sv - self-checking bench for rv_decode_stage
module tb_rv_decode_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = 32'h0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [5:0]  out_alu_cntrl;
  logic        out_mem_to_reg, out_load, out_store, out_jump, out_lui, out_illegal;
  logic [5:0]  out_branch;
  logic [2:0]  out_funct3;
  logic [3:0]  timer_en;
  logic [7:0]  illegal_cnt;

  logic        d2_in_ready, d2_out_valid;
  logic [5:0]  d2_alu;
  logic        d2_mtr, d2_ld, d2_st, d2_jmp, d2_lui, d2_ill;
  logic [5:0]  d2_br;
  logic [2:0]  d2_f3;
  logic [3:0]  d2_timer_en;
  logic [1:0]  d2_illegal_cnt;

  always #5 clk = ~clk;

  rv_decode_stage #(.ALU_W(6), .TIMER_CH(4), .ERR_CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_alu_cntrl(out_alu_cntrl),
    .out_mem_to_reg(out_mem_to_reg), .out_load(out_load), .out_store(out_store),
    .out_jump(out_jump), .out_lui(out_lui), .out_branch(out_branch),
    .out_illegal(out_illegal), .out_funct3(out_funct3), .timer_en(timer_en),
    .illegal_cnt(illegal_cnt)
  );

  rv_decode_stage #(.ALU_W(6), .TIMER_CH(4), .ERR_CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(d2_in_ready), .in_instr(in_instr),
    .out_valid(d2_out_valid), .out_ready(out_ready), .out_alu_cntrl(d2_alu),
    .out_mem_to_reg(d2_mtr), .out_load(d2_ld), .out_store(d2_st),
    .out_jump(d2_jmp), .out_lui(d2_lui), .out_branch(d2_br),
    .out_illegal(d2_ill), .out_funct3(d2_f3), .timer_en(d2_timer_en),
    .illegal_cnt(d2_illegal_cnt)
  );

  typedef struct {
    logic [31:0] instr;
    logic [5:0]  alu;
    logic [4:0]  strb;   // {mem_to_reg, load, store, jump, lui}
    logic [5:0]  br;
    logic        ill;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;
  int   exp_cnt = 0;
  logic [20:0] mon_got, mon_exp;

  // Scoreboard: every transferred bundle is compared with the oldest expectation.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      n_checks++;
      mon_got = {out_alu_cntrl, out_mem_to_reg, out_load, out_store, out_jump, out_lui,
                 out_branch, out_illegal, out_funct3};
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output got=%h", mon_got);
      end else begin
        mon_e = sb_q.pop_front();
        mon_exp = {mon_e.alu, mon_e.strb, mon_e.br, mon_e.ill, mon_e.instr[14:12]};
        if (mon_got !== mon_exp) begin
          n_fail++;
          $display("FAIL bundle instr=%h got=%h expected=%h", mon_e.instr, mon_got, mon_exp);
        end
      end
    end
  end

  task automatic send(input logic [31:0] instr, input logic [5:0] alu, input logic [4:0] strb,
                      input logic [5:0] br, input logic ill);
    exp_t e;
    int   guard;
    e.instr = instr; e.alu = alu; e.strb = strb; e.br = br; e.ill = ill;
    sb_q.push_back(e);
    in_valid = 1'b1;
    in_instr = instr;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout instr=%h in_ready=%b expected=1", instr, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int guard = 0;
    while (sb_q.size() != 0 && guard < 50) begin
      @(posedge clk);
      guard++;
    end
    #1;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain pending=%0d expected=0", name, sb_q.size());
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_handshake out_valid,in_ready=%b expected=01", {out_valid, in_ready});
    end
    n_checks++;
    if ({out_alu_cntrl, out_mem_to_reg, out_load, out_store, out_jump, out_lui, out_branch,
         out_illegal, out_funct3} !== {6'h3F, 15'b0}) begin
      n_fail++;
      $display("FAIL reset_bundle alu=%0d branch=%b illegal=%b funct3=%b expected alu=63 rest 0",
               out_alu_cntrl, out_branch, out_illegal, out_funct3);
    end
    n_checks++;
    if (timer_en !== 4'b0 || illegal_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_state timer_en=%b illegal_cnt=%0d expected 0/0", timer_en, illegal_cnt);
    end
  endtask

  task automatic test_alu;
    logic [31:0] ins [6] = '{32'h002081B3, 32'h402081B3, 32'h40005013, 32'h00005013,
                              32'h40209133, 32'h0000C183};
    logic [5:0]  alu [6] = '{6'd0, 6'd1, 6'd7, 6'd15, 6'd63, 6'd21};
    logic [4:0]  stb [6] = '{5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 5'b11000};
    logic        ill [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(ins[i], alu[i], stb[i], 6'b0, ill[i]);
      if (ill[i]) exp_cnt++;
      n_checks++;
      if (out_valid !== 1'b1 || out_alu_cntrl !== alu[i]) begin
        n_fail++;
        $display("FAIL alu_latency idx=%0d out_valid=%b alu=%0d expected 1/%0d",
                 i, out_valid, out_alu_cntrl, alu[i]);
      end
    end
    wait_empty("alu");
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    send(32'h0000A183, 6'd20, 5'b11000, 6'b0, 1'b0);
    send(32'h0020A023, 6'd25, 5'b00100, 6'b0, 1'b0);
    n_checks++;
    if ({in_ready, out_valid, out_alu_cntrl} !== {1'b0, 1'b1, 6'd20}) begin
      n_fail++;
      $display("FAIL bp_full in_ready=%b out_valid=%b alu=%0d expected 0/1/20",
               in_ready, out_valid, out_alu_cntrl);
    end
    fork
      send(32'h00208063, 6'd26, 5'b0, 6'b000001, 1'b0);
      begin
        repeat (2) begin
          @(posedge clk);
          #1;
          n_checks++;
          if ({in_ready, out_valid, out_alu_cntrl} !== {1'b0, 1'b1, 6'd20}) begin
            n_fail++;
            $display("FAIL bp_stable in_ready=%b out_valid=%b alu=%0d expected 0/1/20",
                     in_ready, out_valid, out_alu_cntrl);
          end
        end
        out_ready = 1'b1;
      end
    join
    wait_empty("backpressure");
  endtask

  task automatic test_timer;
    logic [31:0] ins [6] = '{32'h04000025, 32'h04007025, 32'h00000025, 32'h0A000025,
                              32'h00001025, 32'h00004025};
    logic [5:0]  alu [6] = '{6'd63, 6'd63, 6'd63, 6'd63, 6'd33, 6'd35};
    logic        ill [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0]  ten [6] = '{4'b0100, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(ins[i], alu[i], 5'b0, 6'b0, ill[i]);
      if (ill[i]) exp_cnt++;
      n_checks++;
      if (timer_en !== ten[i] || illegal_cnt !== 8'(exp_cnt)) begin
        n_fail++;
        $display("FAIL timer_state idx=%0d timer_en=%b illegal_cnt=%0d expected %b/%0d",
                 i, timer_en, illegal_cnt, ten[i], exp_cnt);
      end
    end
    wait_empty("timer");
  endtask

  task automatic test_illegal;
    logic [31:0] ins [5] = '{32'hFFFFFFFF, 32'h0000F183, 32'h40001013, 32'h0020B023, 32'h0020A063};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(ins[i], 6'd63, 5'b0, 6'b0, 1'b1);
      exp_cnt++;
      n_checks++;
      if (illegal_cnt !== 8'(exp_cnt)) begin
        n_fail++;
        $display("FAIL illegal_cnt idx=%0d got=%0d expected=%0d", i, illegal_cnt, exp_cnt);
      end
      n_checks++;
      if (d2_illegal_cnt !== ((exp_cnt > 3) ? 2'd3 : 2'(exp_cnt))) begin
        n_fail++;
        $display("FAIL illegal_cnt_sat idx=%0d got=%0d expected=%0d", i, d2_illegal_cnt,
                 (exp_cnt > 3) ? 3 : exp_cnt);
      end
    end
    wait_empty("illegal");
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    send(32'h02000025, 6'd63, 5'b0, 6'b0, 1'b0);
    send(32'h002081B3, 6'd0, 5'b0, 6'b0, 1'b0);
    n_checks++;
    if ({in_ready, out_valid, timer_en} !== {1'b0, 1'b1, 4'b0011}) begin
      n_fail++;
      $display("FAIL rstmid_full in_ready=%b out_valid=%b timer_en=%b expected 0/1/0011",
               in_ready, out_valid, timer_en);
    end
    reset = 1'b1;
    sb_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_cnt = 0;
    n_checks++;
    if ({out_valid, in_ready, timer_en, illegal_cnt} !== {1'b0, 1'b1, 4'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL rstmid_after out_valid=%b in_ready=%b timer_en=%b cnt=%0d expected 0/1/0000/0",
               out_valid, in_ready, timer_en, illegal_cnt);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_discard out_valid=%b expected=0", out_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] ins [5] = '{32'h0020E063, 32'h0020F063, 32'h000100E7, 32'h123452B7, 32'h0000006F};
    logic [5:0]  alu [5] = '{6'd30, 6'd31, 6'd38, 6'd37, 6'd32};
    logic [4:0]  stb [5] = '{5'b0, 5'b0, 5'b00010, 5'b00001, 5'b00010};
    logic [5:0]  br  [5] = '{6'b010000, 6'b100000, 6'b0, 6'b0, 6'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(ins[i], alu[i], stb[i], br[i], 1'b0);
      n_checks++;
      if ({out_valid, in_ready, out_alu_cntrl, out_branch} !== {1'b1, 1'b1, alu[i], br[i]}) begin
        n_fail++;
        $display("FAIL b2b_rate idx=%0d valid=%b ready=%b alu=%0d br=%b expected 1/1/%0d/%b",
                 i, out_valid, in_ready, out_alu_cntrl, out_branch, alu[i], br[i]);
      end
    end
    wait_empty("b2b");
  endtask

  initial begin
    test_reset;
    test_alu;
    test_backpressure;
    test_timer;
    test_illegal;
    test_reset_mid;
    test_back_to_back;
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog sim_time=%0t expected completion", $time);
    $fatal(1, "watchdog");
  end

endmodule
